// File: rtl/arm_exe_pkg.sv
// Shared types and combinational helpers for the ARM execute stage.
// Latency: pure functions and types, no state.
// Backpressure: none; consumers decide when results are used.
package arm_exe_pkg;

  // Widest datapath the helper functions handle; callers zero-extend into it.
  localparam int MAX_W = 64;

  // Bit positions inside the NZCV flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_ORR = 4'b0011,
    OP_EOR = 4'b0100,
    OP_MOV = 4'b0101,
    OP_LSL = 4'b0110,
    OP_LSR = 4'b0111,
    OP_MUL = 4'b1000
  } alu_op_e;

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_W       = 2'b01,
    FWD_M       = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  // ALU result plus per-op flag write permissions.
  typedef struct packed {
    logic [MAX_W-1:0] res;
    logic             n;
    logic             z;
    logic             c;
    logic             v;
    logic             nz_ok;  // op is a defined single-cycle op
    logic             cv_ok;  // op is ADD or SUB
  } alu_res_t;

  // ARM condition check against the current NZCV value; 1111 behaves as always.
  function automatic logic cond_pass(input cond_e cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      C_EQ:    return z;
      C_NE:    return ~z;
      C_CS:    return c;
      C_CC:    return ~c;
      C_MI:    return n;
      C_PL:    return ~n;
      C_VS:    return v;
      C_VC:    return ~v;
      C_HI:    return c & ~z;
      C_LS:    return ~c | z;
      C_GE:    return n == v;
      C_LT:    return n != v;
      C_GT:    return ~z & (n == v);
      C_LE:    return z | (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Single-cycle ALU evaluated at width w; operands must already fit in w bits.
  function automatic alu_res_t alu_f(input alu_op_e op, input logic [MAX_W-1:0] a,
                                     input logic [MAX_W-1:0] b, input int unsigned w);
    alu_res_t         r;
    logic [MAX_W-1:0] one;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] msb;
    logic [MAX_W-1:0] bop;
    logic [MAX_W:0]   sum;
    int unsigned      sh;
    one  = {{(MAX_W-1){1'b0}}, 1'b1};
    mask = (w >= MAX_W) ? {MAX_W{1'b1}} : ((one << w) - one);
    msb  = mask ^ (mask >> 1);
    sh   = 32'(b[5:0]) & (w - 1);
    // SUB is A + ~B + 1 so carry-out is directly NOT borrow.
    bop  = (op == OP_SUB) ? (~b & mask) : b;
    sum  = {1'b0, a} + {1'b0, bop} + {{MAX_W{1'b0}}, (op == OP_SUB)};
    r    = '0;
    case (op)
      OP_ADD, OP_SUB: begin r.res = sum[MAX_W-1:0] & mask; r.nz_ok = 1'b1; r.cv_ok = 1'b1; end
      OP_AND: begin r.res = a & b;            r.nz_ok = 1'b1; end
      OP_ORR: begin r.res = a | b;            r.nz_ok = 1'b1; end
      OP_EOR: begin r.res = a ^ b;            r.nz_ok = 1'b1; end
      OP_MOV: begin r.res = b;                r.nz_ok = 1'b1; end
      OP_LSL: begin r.res = (a << sh) & mask; r.nz_ok = 1'b1; end
      OP_LSR: begin r.res = a >> sh;          r.nz_ok = 1'b1; end
      default: r.res = '0;
    endcase
    r.n = |(r.res & msb);
    r.z = (r.res == '0);
    r.c = |(sum >> w);
    r.v = (|(a & msb) == |(bop & msb)) && (r.n != |(a & msb));
    return r;
  endfunction

endpackage

// File: rtl/execute_stage_mc_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// Latency: start in cycle t, done (with product valid combinationally) in cycle t+WIDTH.
// Backpressure: none; abort or reset returns it to idle at the next edge.
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] step;

  // One partial-product accumulation per cycle; the final step feeds product directly.
  assign step    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy    = busy_q;
  assign done    = busy_q & (cnt_q == '0);
  assign product = step;

  // Shift multiplicand left and multiplier right each busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(WIDTH - 1);
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (busy_q) begin
      if (abort || done) busy_q <= 1'b0;
      cnt_q    <= cnt_q - 1'b1;
      acc_q    <= step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

endmodule

// File: rtl/execute_stage_mc.sv
// ARM E stage: forwarding, ALU, NZCV flags, iterative MUL and the EX/MEM register.
// Latency: 1 cycle for ALU ops; MUL result reaches M WIDTH+1 cycles after acceptance.
// Backpressure: StallE holds F/D/E while a MUL iterates; bubbles enter M meanwhile.
module execute_stage_mc
  import arm_exe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RA_W   = 4,
  parameter int MUL_EN = 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             ValidE,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] dataRegAIn,
  input  logic [WIDTH-1:0] dataRegBIn,
  input  logic [WIDTH-1:0] extIn,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic             ALUSrcE,
  input  logic [3:0]       ALUControlE,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemToRegE,
  input  logic             PCSrcE,
  input  logic             BranchE,
  input  logic [RA_W-1:0]  WA3E,
  output logic             StallE,
  output logic             BranchTakenE,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [RA_W-1:0]  WA3M,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemToRegM,
  output logic             PCSrcM,
  output logic [3:0]       FlagsOut
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]       state_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] src_b;
  logic             cond_ok;
  logic             exec;
  logic             mul_start;
  logic             mul_abort;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  alu_res_t         alu_r;

  // Control captured when a MUL is accepted; E inputs are ignored while it iterates.
  logic             mul_rw_q, mul_mw_q, mul_m2r_q, mul_pcs_q, mul_fnz_q;
  logic [RA_W-1:0]  mul_wa_q;
  logic [WIDTH-1:0] mul_wd_q;

  // Operand forwarding; 11 falls back to the register-file value.
  always_comb begin
    src_a = dataRegAIn;
    fwd_b = dataRegBIn;
    case (fwd_sel_e'(ForwardAE))
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = ALUResultM;
      default: src_a = dataRegAIn;
    endcase
    case (fwd_sel_e'(ForwardBE))
      FWD_W:   fwd_b = ResultW;
      FWD_M:   fwd_b = ALUResultM;
      default: fwd_b = dataRegBIn;
    endcase
  end

  assign src_b     = ALUSrcE ? extIn : fwd_b;
  assign cond_ok   = cond_pass(cond_e'(CondE), flags_q);
  assign exec      = ValidE & cond_ok & ~FlushE;
  assign mul_start = (state_q == S_IDLE) & exec & (ALUControlE == OP_MUL) & (MUL_EN != 0);
  assign mul_abort = (state_q == S_MUL) & FlushE;
  assign alu_r     = alu_f(alu_op_e'(ALUControlE), MAX_W'(src_a), MAX_W'(src_b), 32'(WIDTH));

  // Stall through the iteration, releasing on the final step so upstream advances with it.
  assign StallE       = mul_start | ((state_q == S_MUL) & mul_busy & ~mul_done & ~FlushE);
  assign BranchTakenE = BranchE & exec;
  assign FlagsOut     = flags_q;

  generate
    if (WIDTH < MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^alu_r.res[MAX_W-1:WIDTH];
    end
  endgenerate

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (Clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // IDLE/MUL sequencing, flag register and EX/MEM register; bubbles clear control only.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      flags_q    <= 4'b0000;
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemToRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
      mul_rw_q   <= 1'b0;
      mul_mw_q   <= 1'b0;
      mul_m2r_q  <= 1'b0;
      mul_pcs_q  <= 1'b0;
      mul_fnz_q  <= 1'b0;
      mul_wa_q   <= '0;
      mul_wd_q   <= '0;
    end else begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MemToRegM <= 1'b0;
      PCSrcM    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mul_start) begin
            state_q   <= S_MUL;
            mul_rw_q  <= RegWriteE;
            mul_mw_q  <= MemWriteE;
            mul_m2r_q <= MemToRegE;
            mul_pcs_q <= PCSrcE;
            mul_fnz_q <= FlagWriteE[1];
            mul_wa_q  <= WA3E;
            mul_wd_q  <= fwd_b;
          end else if (exec) begin
            ALUResultM <= alu_r.res[WIDTH-1:0];
            WriteDataM <= fwd_b;
            WA3M       <= WA3E;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            MemToRegM  <= MemToRegE;
            PCSrcM     <= PCSrcE;
            if (FlagWriteE[1] && alu_r.nz_ok) begin
              flags_q[FLAG_N] <= alu_r.n;
              flags_q[FLAG_Z] <= alu_r.z;
            end
            if (FlagWriteE[0] && alu_r.cv_ok) begin
              flags_q[FLAG_C] <= alu_r.c;
              flags_q[FLAG_V] <= alu_r.v;
            end
          end
        end
        default: begin
          if (FlushE) begin
            state_q <= S_IDLE;
          end else if (mul_done) begin
            state_q    <= S_IDLE;
            ALUResultM <= mul_prod;
            WriteDataM <= mul_wd_q;
            WA3M       <= mul_wa_q;
            RegWriteM  <= mul_rw_q;
            MemWriteM  <= mul_mw_q;
            MemToRegM  <= mul_m2r_q;
            PCSrcM     <= mul_pcs_q;
            if (mul_fnz_q) begin
              flags_q[FLAG_N] <= mul_prod[WIDTH-1];
              flags_q[FLAG_Z] <= (mul_prod == '0);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/execute_stage_mc.md
# execute_stage_mc

Parametrised execute stage for the pipelined ARM core. It sits between the decode/register-read stage and the memory stage, and owns the E-stage datapath:
- 3-way operand forwarding.
- ALU.
- NZCV flag register and condition check.
- An iterative multi-cycle multiplier that stalls upstream while busy.
- The EX/MEM pipeline register.

## Interface
Parameters:
- WIDTH, 32, datapath width (power of two, ≥8)
- RA_W, 4, register address width
- MUL_EN, 1, 1 = MUL supported; 0 = MUL executes as reserved op

Ports (Clk, reset: one clock; reset is synchronous and active-high):
- Clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ValidE  in  1  E-stage holds a real instruction
- FlushE  in  1  kill E-stage instruction (branch redirect)
- dataRegAIn, dataRegBIn  in  WIDTH  register-file operands
- extIn  in  WIDTH  extended immediate
- ResultW  in  WIDTH  writeback result for forwarding
- ForwardAE, ForwardBE  in  2  00 reg, 01 ResultW, 10 ALUResultM, 11 reg
- ALUSrcE  in  1  1 = operand B is extIn (after forwarding mux, B data still goes to WriteDataM)
- ALUControlE  in  4  op code (see Operation)
- CondE  in  4  ARM condition field
- FlagWriteE  in  2  [1] write N,Z; [0] write C,V
- RegWriteE, MemWriteE, MemToRegE, PCSrcE, BranchE  in  1  control
- WA3E  in  RA_W  destination register
- StallE  out  1  hold F/D/E stages
- BranchTakenE  out  1  BranchE & ValidE & condition passed & ~FlushE
- ALUResultM, WriteDataM  out  WIDTH  registered result / store data
- WA3M  out  RA_W  registered destination
- RegWriteM, MemWriteM, MemToRegM, PCSrcM  out  1  registered, gated by condition
- FlagsOut  out  4  current NZCV

## Operation
- Ops:
  - 0000 ADD
  - 0001 SUB (A−B)
  - 0010 AND
  - 0011 ORR
  - 0100 EOR
  - 0101 MOV (B)
  - 0110 LSL
  - 0111 LSR
  - 1000 MUL (low WIDTH bits of A×B)
  - others reserved → result 0, no flag write
- Shift amount = B[$clog2(WIDTH)-1:0]; result is modulo 2^WIDTH.
- C,V are written only by ADD/SUB:
  - C = carry-out for ADD, NOT borrow for SUB.
  - V = signed overflow.
- N,Z are written by any non-reserved op when FlagWriteE[1].
- The condition is evaluated against the flag register value before this instruction's update.
- An instruction executes only if ValidE & condition passed & ~FlushE; otherwise a bubble enters M:
  - RegWriteM, MemWriteM, PCSrcM, MemToRegM = 0.
  - No flag write, no multiply start.
- FSM IDLE/MUL:
  - IDLE → MUL when an executing MUL is present (MUL_EN=1). Operands, control and WA3E are latched, and count = WIDTH−1.
  - In MUL, the multiplier performs one shift-add step per cycle and count decrements.
  - When count==0, the product and latched control load into the M register, N,Z update if latched FlagWriteE[1], and the FSM returns to IDLE.
- FlushE or reset while in MUL aborts: the FSM returns to IDLE, StallE drops, a bubble enters M, and there is no flag write.
- FlushE and a MUL start in the same cycle: flush wins.

## Timing
- Non-MUL ops: 1 cycle; the result is visible on the M outputs the cycle after E.
- MUL accepted in cycle t:
  - StallE = 1 in cycles t..t+WIDTH−1 (combinational in cycle t).
  - Bubbles enter M during t..t+WIDTH−1.
  - The product is on ALUResultM in cycle t+WIDTH+1.
  - StallE = 0 in cycle t+WIDTH, so upstream advances at that edge.
- Forward select 10 uses the ALUResultM register value in the current cycle.
- Reset values: all M outputs 0, FlagsOut 0000, StallE 0, FSM IDLE.

## Structure
- Package arm_exe_pkg holds:
  - the alu_op_e enum (above codes),
  - the cond_e enum (EQ…AL),
  - the fwd_sel_e enum,
  - flag bit index constants.
- Sub-module mul_iter (WIDTH): start/abort/busy/done, shift-add, product output.
- The ALU and condition check are combinational functions in the package.

## Test plan
- WIDTH=32: A=5, B=2, SUB, FlagWriteE=11, AL → next cycle ALUResultM=3, FlagsOut=0010 (C set).
- ForwardAE=01 with ResultW=7, ForwardBE=10 with ALUResultM=3, ADD → ALUResultM=10.
- Set Z via SUB 4−4. Then ADD marked NE with RegWriteE=1 → RegWriteM=0, flags unchanged. Then EQ → executes.
- MUL 6×7 in cycle t:
  - StallE high for 32 cycles, M bubbles.
  - ALUResultM=42 in cycle t+33.
  - Operand changes on inputs during the stall are ignored.
- MUL 0xFFFF_FFFF×2 → 0xFFFF_FFFE, N=1. Then LSL 1 by 31 → 0x8000_0000; LSR by 32 (amount field 0) → A unchanged.
- Abort cases:
  - Reset asserted at mid-MUL cycle t+10 → StallE=0 and all outputs 0 the next cycle.
  - FlushE asserted at cycle t+5 → StallE drops and a bubble enters M, with no flag change.
